// File: rtl/ring_bram_mp_pkg.sv
// Shared convolution-path definitions: default pixel width and KxK tap count.
package ring_bram_mp_pkg;

  localparam int unsigned CONV_DATA_WIDTH = 8;
  localparam int unsigned CONV_K          = 3;
  localparam int unsigned CONV_TAPS       = CONV_K * CONV_K;

endpackage

// File: rtl/ring_bram_mp_ring_addr_add.sv
// ring_addr_add: combinational (base + off) mod DEPTH.
// The result is exact for base < DEPTH and off <= DEPTH. Larger offsets give
// an undefined address, which callers flag separately.
module ring_addr_add #(
  parameter int unsigned DEPTH      = 21,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   off,
  output logic [ADDR_WIDTH-1:0] sum
);

  localparam logic [ADDR_WIDTH+1:0] DEPTH_W = (ADDR_WIDTH+2)'(DEPTH);

  logic [ADDR_WIDTH+1:0] raw;

  // Add, then fold back by a single subtraction of DEPTH.
  always_comb begin
    raw = {2'b00, base} + {1'b0, off};
    sum = ADDR_WIDTH'((raw >= DEPTH_W) ? (raw - DEPTH_W) : raw);
  end

endmodule

// File: rtl/ring_bram_mp.sv
// ring_bram_mp: circular feature-line buffer with one streaming write port and
// RD_PORTS parallel read ports addressed relative to a sliding read base.
// Optional macro RING_BRAM_BYPASS_EN: write-first forwarding on same-address
// read/write collisions; without it the array is read-first.
module ring_bram_mp
  import ring_bram_mp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CONV_DATA_WIDTH,
  parameter int unsigned DEPTH      = 21,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned RD_PORTS   = CONV_TAPS,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_wr_valid,
  output logic                           o_wr_ready,
  input  logic [DATA_WIDTH-1:0]          i_wr_data,
  input  logic                           i_rd_valid,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0] i_rd_offs,
  output logic                           o_rd_valid,
  output logic [RD_PORTS*DATA_WIDTH-1:0] o_rd_data,
  output logic [RD_PORTS-1:0]            o_rd_err,
  input  logic                           i_rel_valid,
  input  logic [ADDR_WIDTH:0]            i_rel_cnt,
  output logic [ADDR_WIDTH:0]            o_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_base;
  logic [ADDR_WIDTH-1:0] rd_base_next;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_next;
  logic [ADDR_WIDTH:0]   rel_n;
  logic                  wr_ready_q;
  logic                  wr_fire;

  logic [ADDR_WIDTH-1:0] rd_addr [RD_PORTS];
  logic [RD_PORTS-1:0]   rd_err_now;

  logic                           s1_valid;
  logic [RD_PORTS*DATA_WIDTH-1:0] s1_data;
  logic [RD_PORTS-1:0]            s1_err;

  // Handshake, release clamp and next occupancy.
  always_comb begin
    wr_fire    = i_wr_valid && wr_ready_q && !i_rst;
    rel_n      = '0;
    if (i_rel_valid) begin
      rel_n = (i_rel_cnt < count_q) ? i_rel_cnt : count_q;
    end
    count_next = count_q + {{ADDR_WIDTH{1'b0}}, wr_fire} - rel_n;
  end

  // The same modular adder that resolves read addresses also advances the base.
  ring_addr_add #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rel_add (
    .base (rd_base),
    .off  (rel_n),
    .sum  (rd_base_next)
  );

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
    ring_addr_add #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd_add (
      .base (rd_base),
      .off  ({1'b0, i_rd_offs[p*ADDR_WIDTH +: ADDR_WIDTH]}),
      .sum  (rd_addr[p])
    );
    // Offsets at or beyond current occupancy (including >= DEPTH) are stale.
    assign rd_err_now[p] = ({1'b0, i_rd_offs[p*ADDR_WIDTH +: ADDR_WIDTH]} >= count_q);
  end

  // Pointer, base, occupancy and registered ready.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_base    <= '0;
      count_q    <= '0;
      wr_ready_q <= 1'b1;
    end else begin
      if (wr_fire) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      rd_base    <= rd_base_next;
      count_q    <= count_next;
      wr_ready_q <= (count_next < DEPTH_C);
    end
  end

  // Array write port; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= i_wr_data;
    end
  end

  // First read stage: registered array read for every port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_err   <= '0;
    end else begin
      s1_valid <= i_rd_valid;
      if (i_rd_valid) begin
        s1_err <= rd_err_now;
        for (int unsigned p = 0; p < RD_PORTS; p++) begin
`ifdef RING_BRAM_BYPASS_EN
          if (wr_fire && (rd_addr[p] == wr_ptr)) begin
            s1_data[p*DATA_WIDTH +: DATA_WIDTH] <= i_wr_data;
          end else begin
            s1_data[p*DATA_WIDTH +: DATA_WIDTH] <= mem[rd_addr[p]];
          end
`else
          s1_data[p*DATA_WIDTH +: DATA_WIDTH] <= mem[rd_addr[p]];
`endif
        end
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                           s2_valid;
    logic [RD_PORTS*DATA_WIDTH-1:0] s2_data;
    logic [RD_PORTS-1:0]            s2_err;

    // Optional output register stage.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
        s2_err   <= '0;
      end else begin
        s2_valid <= s1_valid;
        s2_data  <= s1_data;
        s2_err   <= s1_err;
      end
    end

    assign o_rd_valid = s2_valid;
    assign o_rd_data  = s2_data;
    assign o_rd_err   = s2_err;
  end else begin : g_lat1
    assign o_rd_valid = s1_valid;
    assign o_rd_data  = s1_data;
    assign o_rd_err   = s1_err;
  end

  assign o_wr_ready = wr_ready_q;
  assign o_count    = count_q;

endmodule

// File: tb/tb_ring_bram_mp.sv
// Bench for ring_bram_mp: directed scenarios plus randomized traffic against a
// queue-style occupancy/array model. A second instance runs RD_LATENCY=2 on the
// same stimulus. Honours RING_BRAM_BYPASS_EN for collision expectations.
module tb_ring_bram_mp;

  localparam int DW    = 8;
  localparam int DEPTH = 21;
  localparam int AW    = 6;
  localparam int RP    = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, wr_valid, rd_valid, rel_valid;
  logic [DW-1:0]    wr_data;
  logic [RP*AW-1:0] rd_offs;
  logic [AW:0]      rel_cnt;

  logic             wr_ready, rdv, wr_ready2, rdv2;
  logic [RP*DW-1:0] rd_data, rd_data2;
  logic [RP-1:0]    rd_err, rd_err2;
  logic [AW:0]      count, count2;

  ring_bram_mp #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .RD_PORTS(RP), .RD_LATENCY(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data),
    .i_rd_valid(rd_valid), .i_rd_offs(rd_offs), .o_rd_valid(rdv), .o_rd_data(rd_data),
    .o_rd_err(rd_err), .i_rel_valid(rel_valid), .i_rel_cnt(rel_cnt), .o_count(count)
  );

  ring_bram_mp #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .RD_PORTS(RP), .RD_LATENCY(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready2), .i_wr_data(wr_data),
    .i_rd_valid(rd_valid), .i_rd_offs(rd_offs), .o_rd_valid(rdv2), .o_rd_data(rd_data2),
    .o_rd_err(rd_err2), .i_rel_valid(rel_valid), .i_rel_cnt(rel_cnt), .o_count(count2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: physical array contents plus logical base/occupancy.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_wr  [DEPTH];
  int            m_base, m_count;

  // Expected read results one and two cycles after a request.
  bit            e1_v, e2_v;
  logic [DW-1:0] e1_d [RP];
  logic [DW-1:0] e2_d [RP];
  bit            e1_c [RP];
  bit            e2_c [RP];
  logic [RP-1:0] e1_e, e2_e;

  task automatic set_off(input int p, input int v);
    rd_offs[p*AW +: AW] = AW'(v);
  endtask

  task automatic idle();
    wr_valid  = 1'b0;
    rd_valid  = 1'b0;
    rel_valid = 1'b0;
  endtask

  // Advance the model by one cycle using the currently driven inputs, then clock.
  task automatic tick();
    int wa, n, off, a;
    bit wf;
    e2_v = e1_v; e2_d = e1_d; e2_c = e1_c; e2_e = e1_e;
    if (rst) begin
      m_base = 0; m_count = 0;
      e1_v = 0; e2_v = 0; e1_e = '0; e2_e = '0;
      for (int p = 0; p < RP; p++) begin
        e1_d[p] = '0; e2_d[p] = '0; e1_c[p] = 1; e2_c[p] = 1;
      end
    end else begin
      wf = wr_valid && (m_count < DEPTH);
      wa = (m_base + m_count) % DEPTH;
      e1_v = rd_valid;
      if (rd_valid) begin
        for (int p = 0; p < RP; p++) begin
          off = int'(rd_offs[p*AW +: AW]);
          e1_e[p] = (off >= m_count);
          if (off < DEPTH) begin
            a = (m_base + off) % DEPTH;
            e1_d[p] = m_mem[a];
            e1_c[p] = m_wr[a];
`ifdef RING_BRAM_BYPASS_EN
            if (wf && a == wa) begin
              e1_d[p] = wr_data;
              e1_c[p] = 1;
            end
`endif
          end else begin
            e1_c[p] = 0;
          end
        end
      end
      n = rel_valid ? ((int'(rel_cnt) < m_count) ? int'(rel_cnt) : m_count) : 0;
      if (wf) begin
        m_mem[wa] = wr_data;
        m_wr[wa]  = 1;
      end
      m_base  = (m_base + n) % DEPTH;
      m_count = m_count + int'(wf) - n;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); tick(); rst = 1'b0;
    n_cmp++; if (count !== 7'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", wr_ready); end
    n_cmp++; if (rdv !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid got %b want 0", rdv); end
    n_cmp++; if (rd_data !== '0) begin n_bad++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    n_cmp++; if (rd_err !== '0) begin n_bad++; $display("FAIL reset_rd_err got %b want 0", rd_err); end
    n_cmp++; if (rdv2 !== 1'b0 || rd_data2 !== '0 || rd_err2 !== '0) begin
      n_bad++; $display("FAIL reset_lat2 got v=%b d=%h e=%b want zeros", rdv2, rd_data2, rd_err2);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      wr_valid = 1'b1; wr_data = DW'(i); tick();
    end
    idle();
    n_cmp++; if (count !== 7'd21) begin n_bad++; $display("FAIL fill_count got %0d want 21", count); end
    n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready got %b want 0", wr_ready); end
    wr_valid = 1'b1; wr_data = 8'd99; tick(); idle();
    n_cmp++; if (count !== 7'd21) begin n_bad++; $display("FAIL full_write_count got %0d want 21", count); end
  endtask

  task automatic test_read_full();
    rd_valid = 1'b1;
    for (int p = 0; p < RP; p++) set_off(p, p);
    tick(); idle();
    n_cmp++; if (rdv !== 1'b1) begin n_bad++; $display("FAIL rd_full_valid got %b want 1", rdv); end
    n_cmp++; if (rd_err !== '0) begin n_bad++; $display("FAIL rd_full_err got %b want 0", rd_err); end
    n_cmp++; if (rdv2 !== 1'b0) begin n_bad++; $display("FAIL rd_full_lat2_early got %b want 0", rdv2); end
    for (int p = 0; p < RP; p++) begin
      n_cmp++;
      if (rd_data[p*DW +: DW] !== DW'(p + 1)) begin
        n_bad++; $display("FAIL rd_full_data[%0d] got %0d want %0d", p, rd_data[p*DW +: DW], p + 1);
      end
    end
    tick();
    n_cmp++; if (rdv2 !== 1'b1 || rdv !== 1'b0) begin
      n_bad++; $display("FAIL rd_full_lat2_valid got %b/%b want 1/0", rdv2, rdv);
    end
    for (int p = 0; p < RP; p++) begin
      n_cmp++;
      if (rd_data2[p*DW +: DW] !== DW'(p + 1)) begin
        n_bad++; $display("FAIL rd_full_lat2_data[%0d] got %0d want %0d", p, rd_data2[p*DW +: DW], p + 1);
      end
    end
  endtask

  task automatic test_wrap();
    int exp_d [RP];
    exp_d = '{21, 22, 23, 24, 25, 6, 7, 8, 9};
    rel_valid = 1'b1; rel_cnt = 7'd5; tick(); idle();
    n_cmp++; if (count !== 7'd16) begin n_bad++; $display("FAIL wrap_rel_count got %0d want 16", count); end
    for (int i = 22; i <= 26; i++) begin
      wr_valid = 1'b1; wr_data = DW'(i); tick();
    end
    idle();
    n_cmp++; if (count !== 7'd21) begin n_bad++; $display("FAIL wrap_count got %0d want 21", count); end
    rd_valid = 1'b1;
    for (int p = 0; p < 5; p++) set_off(p, 15 + p);
    for (int p = 5; p < RP; p++) set_off(p, p - 5);
    tick(); idle();
    n_cmp++; if (rdv !== 1'b1 || rd_err !== '0) begin
      n_bad++; $display("FAIL wrap_valid_err got v=%b e=%b want 1/0", rdv, rd_err);
    end
    for (int p = 0; p < RP; p++) begin
      n_cmp++;
      if (rd_data[p*DW +: DW] !== DW'(exp_d[p])) begin
        n_bad++; $display("FAIL wrap_data[%0d] got %0d want %0d", p, rd_data[p*DW +: DW], exp_d[p]);
      end
    end
  endtask

  task automatic test_clamp();
    rel_valid = 1'b1; rel_cnt = 7'd18; tick();
    n_cmp++; if (count !== 7'd3) begin n_bad++; $display("FAIL clamp_pre_count got %0d want 3", count); end
    rel_cnt = 7'd10; tick(); idle();
    n_cmp++; if (count !== 7'd0) begin n_bad++; $display("FAIL clamp_count got %0d want 0", count); end
    rd_valid = 1'b1;
    for (int p = 0; p < RP; p++) set_off(p, 0);
    tick(); idle();
    n_cmp++; if (rdv !== 1'b1 || rd_err[0] !== 1'b1) begin
      n_bad++; $display("FAIL clamp_err0 got v=%b e=%b want 1/1", rdv, rd_err[0]);
    end
    n_cmp++; if (count !== 7'd0) begin n_bad++; $display("FAIL clamp_post_count got %0d want 0", count); end
  endtask

  task automatic test_wr_rel();
    logic [DW-1:0] vals [11];
    for (int i = 0; i < 10; i++) begin
      vals[i] = DW'($urandom);
      wr_valid = 1'b1; wr_data = vals[i]; tick();
    end
    idle();
    n_cmp++; if (count !== 7'd10) begin n_bad++; $display("FAIL wr_rel_pre_count got %0d want 10", count); end
    vals[10] = DW'($urandom);
    wr_valid = 1'b1; wr_data = vals[10]; rel_valid = 1'b1; rel_cnt = 7'd1; tick(); idle();
    n_cmp++; if (count !== 7'd10) begin n_bad++; $display("FAIL wr_rel_count got %0d want 10", count); end
    rd_valid = 1'b1;
    for (int p = 0; p < RP; p++) set_off(p, p);
    tick(); idle();
    for (int p = 0; p < RP; p++) begin
      n_cmp++;
      if (rd_data[p*DW +: DW] !== vals[p + 1]) begin
        n_bad++; $display("FAIL wr_rel_base_data[%0d] got %0d want %0d", p, rd_data[p*DW +: DW], vals[p + 1]);
      end
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] exp_d;
`ifdef RING_BRAM_BYPASS_EN
    exp_d = 8'd9;
`else
    exp_d = 8'd7;
`endif
    rst = 1'b1; idle(); tick(); rst = 1'b0;
    wr_valid = 1'b1; wr_data = 8'd7; tick(); idle();
    rel_valid = 1'b1; rel_cnt = 7'd1; tick(); idle();
    for (int i = 0; i < 20; i++) begin
      wr_valid = 1'b1; wr_data = DW'(101 + i); tick();
    end
    idle();
    n_cmp++; if (count !== 7'd20) begin n_bad++; $display("FAIL coll_pre_count got %0d want 20", count); end
    wr_valid = 1'b1; wr_data = 8'd9; rd_valid = 1'b1;
    for (int p = 0; p < RP; p++) set_off(p, 20);
    tick(); idle();
    n_cmp++; if (rd_data[DW-1:0] !== exp_d) begin
      n_bad++; $display("FAIL coll_data got %0d want %0d", rd_data[DW-1:0], exp_d);
    end
    n_cmp++; if (rd_err[0] !== 1'b1) begin n_bad++; $display("FAIL coll_err got %b want 1", rd_err[0]); end
    n_cmp++; if (count !== 7'd21) begin n_bad++; $display("FAIL coll_count got %0d want 21", count); end
  endtask

  task automatic test_reset_inflight();
    rd_valid = 1'b1;
    for (int p = 0; p < RP; p++) set_off(p, p);
    tick();
    rd_valid = 1'b0; rst = 1'b1; tick();
    n_cmp++; if (rdv2 !== 1'b0 || rdv !== 1'b0) begin
      n_bad++; $display("FAIL inflight_rst got %b/%b want 0/0", rdv2, rdv);
    end
    rst = 1'b0; idle(); tick();
    n_cmp++; if (rdv2 !== 1'b0 || count !== 7'd0) begin
      n_bad++; $display("FAIL inflight_post got v=%b cnt=%0d want 0/0", rdv2, count);
    end
  endtask

  task automatic test_random();
    int wbias;
    rst = 1'b1; idle(); tick(); rst = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc % 50 == 0) wbias = $urandom_range(20, 95);
      wr_valid  = ($urandom_range(0, 99) < wbias);
      wr_data   = DW'($urandom);
      rel_valid = ($urandom_range(0, 3) == 0);
      rel_cnt   = AW'($urandom_range(0, 6));
      rd_valid  = ($urandom_range(0, 1) == 1);
      for (int p = 0; p < RP; p++) set_off(p, $urandom_range(0, 24));
      tick();
      n_cmp++; if (int'(count) != m_count || count2 !== count) begin
        n_bad++; $display("FAIL rnd_count cyc %0d got %0d/%0d want %0d", cyc, count, count2, m_count);
      end
      n_cmp++; if (wr_ready !== (m_count < DEPTH) || wr_ready2 !== wr_ready) begin
        n_bad++; $display("FAIL rnd_ready cyc %0d got %b/%b want %b", cyc, wr_ready, wr_ready2, m_count < DEPTH);
      end
      n_cmp++; if (rdv !== e1_v || rdv2 !== e2_v) begin
        n_bad++; $display("FAIL rnd_valid cyc %0d got %b/%b want %b/%b", cyc, rdv, rdv2, e1_v, e2_v);
      end
      if (e1_v) begin
        n_cmp++; if (rd_err !== e1_e) begin
          n_bad++; $display("FAIL rnd_err cyc %0d got %b want %b", cyc, rd_err, e1_e);
        end
        for (int p = 0; p < RP; p++) begin
          if (e1_c[p]) begin
            n_cmp++; if (rd_data[p*DW +: DW] !== e1_d[p]) begin
              n_bad++; $display("FAIL rnd_data cyc %0d port %0d got %0d want %0d", cyc, p, rd_data[p*DW +: DW], e1_d[p]);
            end
          end
        end
      end
      if (e2_v) begin
        n_cmp++; if (rd_err2 !== e2_e) begin
          n_bad++; $display("FAIL rnd_err2 cyc %0d got %b want %b", cyc, rd_err2, e2_e);
        end
        for (int p = 0; p < RP; p++) begin
          if (e2_c[p]) begin
            n_cmp++; if (rd_data2[p*DW +: DW] !== e2_d[p]) begin
              n_bad++; $display("FAIL rnd_data2 cyc %0d port %0d got %0d want %0d", cyc, p, rd_data2[p*DW +: DW], e2_d[p]);
            end
          end
        end
      end
    end
    idle();
  endtask

  initial begin
    rst = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; rel_valid = 1'b0;
    wr_data = '0; rd_offs = '0; rel_cnt = '0;
    m_base = 0; m_count = 0; e1_v = 0; e2_v = 0; e1_e = '0; e2_e = '0;
    for (int p = 0; p < RP; p++) begin
      e1_d[p] = '0; e2_d[p] = '0; e1_c[p] = 0; e2_c[p] = 0;
    end
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_read_full();
    test_wrap();
    test_clamp();
    test_wr_rel();
    test_collision();
    test_reset_inflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
